// File: rtl/common_pkg.sv
// Shared types for the status register bank.
// Holds the channel record, default channel count and FSM states.
package common_pkg;

    localparam int STATUS_NUM_CH = 8;

    typedef struct packed {
        logic a;
        logic b;
    } status_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } status_bank_state_e;

    // Port-side view of a record: bit0 is a, bit1 is b.
    function automatic logic [1:0] status_to_ba(status_t s);
        return {s.b, s.a};
    endfunction

endpackage

// File: rtl/status_chan.sv
// One status channel: two sticky flags plus an optional expiry timer.
// Timer present only when STATUS_BANK_TIMEOUT_EN is defined.
module status_chan
    import common_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_en,
    input  logic       clr_en,
    input  logic [1:0] sel,
    input  logic       wipe,
    output status_t    status
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("status_chan: HOLD_CYCLES must be >= 1");
    end

    status_t st_q;
    status_t st_d;
    logic    set_hit;
    logic    expire;

    // A set with an empty mask changes nothing, so it is not a write here.
    assign set_hit = set_en && (|sel);

`ifdef STATUS_BANK_TIMEOUT_EN
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD = TW'(HOLD_CYCLES);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Timer: reload on set, kill on clear/wipe, otherwise count down.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (wipe) begin
            cnt_d = '0;
        end else if (set_hit) begin
            cnt_d = HOLD;
        end else if (clr_en) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - 1'b1;
            expire = (cnt_q == TW'(1));
        end
    end

    // Timer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Flag update: wipe, then write, then expiry (write beats expiry).
    always_comb begin
        st_d = st_q;
        if (wipe) begin
            st_d = '0;
        end else if (set_hit) begin
            st_d.a = st_q.a | sel[0];
            st_d.b = st_q.b | sel[1];
        end else if (clr_en) begin
            st_d.a = st_q.a & ~sel[0];
            st_d.b = st_q.b & ~sel[1];
        end else if (expire) begin
            st_d = '0;
        end
    end

    // Flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign status = st_q;

endmodule

// File: rtl/status_bank.sv
// Multi-channel status flag bank with write port, registered read,
// summaries and sequenced clear-all. Expiry via STATUS_BANK_TIMEOUT_EN.
module status_bank
    import common_pkg::*;
#(
    parameter  int NUM_CH      = STATUS_NUM_CH,
    parameter  int HOLD_CYCLES = 16,
    localparam int CW          = $clog2(NUM_CH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [CW-1:0] wr_ch_i,
    input  logic          wr_set_i,
    input  logic [1:0]    wr_data_i,
    input  logic [CW-1:0] rd_ch_i,
    output logic [1:0]    rd_data_o,
    input  logic          clr_all_i,
    output logic          busy_o,
    output logic          any_a_o,
    output logic          any_b_o
);

    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("status_bank: NUM_CH must be >= 2");
    end

    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    status_bank_state_e state_q;
    status_bank_state_e state_d;
    logic [CW-1:0]      idx_q;
    logic [CW-1:0]      idx_d;

    logic              wr_acc;
    logic [NUM_CH-1:0] set_en;
    logic [NUM_CH-1:0] clr_en;
    logic [NUM_CH-1:0] wipe;
    status_t           flags [NUM_CH];

    logic [1:0] rd_d;
    logic [1:0] rd_q;
    logic       any_a_d;
    logic       any_b_d;
    logic       any_a_q;
    logic       any_b_q;

    // A clear-all request blocks the write port in the same cycle.
    assign wr_ready_o = (state_q == IDLE) && !clr_all_i;
    assign wr_acc     = wr_valid_i && wr_ready_o;

    // Clear-all sequencer: walk idx over every channel once.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_all_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    // Sequencer state and scan index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Per-channel strobes; out-of-range channels match nothing.
    always_comb begin
        set_en = '0;
        clr_en = '0;
        wipe   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            set_en[i] = wr_acc && wr_set_i && (wr_ch_i == CW'(i));
            clr_en[i] = wr_acc && !wr_set_i && (wr_ch_i == CW'(i));
            wipe[i]   = (state_q == CLEAR) && (idx_q == CW'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        status_chan #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_chan (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .set_en(set_en[g]),
            .clr_en(clr_en[g]),
            .sel   (wr_data_i),
            .wipe  (wipe[g]),
            .status(flags[g])
        );
    end

    // Read mux and OR summaries over the current flag state.
    always_comb begin
        rd_d    = '0;
        any_a_d = 1'b0;
        any_b_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_i == CW'(i)) begin
                rd_d = status_to_ba(flags[i]);
            end
            any_a_d = any_a_d | flags[i].a;
            any_b_d = any_b_d | flags[i].b;
        end
    end

    // Output registers for read data and summaries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            any_a_q <= 1'b0;
            any_b_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            any_a_q <= any_a_d;
            any_b_q <= any_b_d;
        end
    end

    assign rd_data_o = rd_q;
    assign any_a_o   = any_a_q;
    assign any_b_o   = any_b_q;
    assign busy_o    = (state_q == CLEAR);

endmodule

// File: tb/tb_status_bank.sv
// Self-checking bench for status_bank (8-channel and 6-channel builds).
// Timeout scenario runs only when STATUS_BANK_TIMEOUT_EN is defined.
module tb_status_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [2:0] wr_ch;
    logic       wr_set;
    logic [1:0] wr_data;
    logic [2:0] rd_ch;
    logic       clr_all;

    logic       wr_ready, busy, any_a, any_b;
    logic [1:0] rd_data;
    logic       wr_ready6, busy6, any_a6, any_b6;
    logic [1:0] rd_data6;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] ch;
        logic [1:0] e8;
        logic [1:0] e6;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 clk = ~clk;

    status_bank #(.NUM_CH(8), .HOLD_CYCLES(1000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_ch_i(wr_ch), .wr_set_i(wr_set), .wr_data_i(wr_data),
        .rd_ch_i(rd_ch), .rd_data_o(rd_data),
        .clr_all_i(clr_all), .busy_o(busy),
        .any_a_o(any_a), .any_b_o(any_b)
    );

    status_bank #(.NUM_CH(6), .HOLD_CYCLES(4)) dut6 (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready6),
        .wr_ch_i(wr_ch), .wr_set_i(wr_set), .wr_data_i(wr_data),
        .rd_ch_i(rd_ch), .rd_data_o(rd_data6),
        .clr_all_i(clr_all), .busy_o(busy6),
        .any_a_o(any_a6), .any_b_o(any_b6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic s, input logic [1:0] d);
        bit done = 0;
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_set   = s;
        wr_data  = d;
        for (int k = 0; k < 40 && !done; k++) begin
            done = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wr_timeout ch%0d: ready got %b, required 1", ch, wr_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 0; wr_ch = 0; wr_set = 0; wr_data = 0; rd_ch = 0; clr_all = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rd_data !== 2'b00) begin n_fail++; $display("FAIL reset_rd: got %b, required 00", rd_data); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_chk++; if (any_a !== 1'b0 || any_b !== 1'b0) begin n_fail++; $display("FAIL reset_any: got %b%b, required 00", any_a, any_b); end
        n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", wr_ready); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_set_read();
        rd_exp_t e;
        wr(3'd3, 1'b1, 2'b01);
        rd_ch = 3'd3;
        sb.push_back('{3'd3, 2'b01, 2'b01});
        tick();
        e = sb.pop_front();
        n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL set_read_ch%0d: got %b, required %b", e.ch, rd_data, e.e8); end
        n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL set_read6_ch%0d: got %b, required %b", e.ch, rd_data6, e.e6); end
        n_chk++; if (any_a !== 1'b1) begin n_fail++; $display("FAIL set_any_a: got %b, required 1", any_a); end
        n_chk++; if (any_b !== 1'b0) begin n_fail++; $display("FAIL set_any_b: got %b, required 0", any_b); end
    endtask

    task automatic test_set_clear();
        rd_exp_t lst [3];
        rd_exp_t e;
        lst[0] = '{3'd0, 2'b01, 2'b01};
        lst[1] = '{3'd7, 2'b11, 2'b00};
        lst[2] = '{3'd3, 2'b01, 2'b01};
        wr(3'd0, 1'b1, 2'b11);
        wr(3'd7, 1'b1, 2'b11);
        wr(3'd0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            rd_ch = lst[i].ch;
            sb.push_back(lst[i]);
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL setclr_ch%0d: got %b, required %b", e.ch, rd_data, e.e8); end
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL setclr6_ch%0d: got %b, required %b", e.ch, rd_data6, e.e6); end
        end
        n_chk++; if (any_a !== 1'b1 || any_b !== 1'b1) begin n_fail++; $display("FAIL setclr_any: got %b%b, required 11", any_a, any_b); end
    endtask

    task automatic test_same_cycle();
        rd_exp_t e;
        wr_valid = 1'b1; wr_ch = 3'd5; wr_set = 1'b1; wr_data = 2'b10;
        rd_ch = 3'd5;
        sb.push_back('{3'd5, 2'b00, 2'b00});
        tick();
        wr_valid = 1'b0;
        e = sb.pop_front();
        n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL same_cycle_old: got %b, required %b", rd_data, e.e8); end
        sb.push_back('{3'd5, 2'b10, 2'b10});
        tick();
        e = sb.pop_front();
        n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL same_cycle_new: got %b, required %b", rd_data, e.e8); end
        n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL same_cycle_new6: got %b, required %b", rd_data6, e.e6); end
    endtask

    task automatic test_clear_all();
        rd_exp_t e;
        int cnt = 0;
        bit saw_ready = 0;
        wr_valid = 1'b1; wr_ch = 3'd4; wr_set = 1'b1; wr_data = 2'b11;
        clr_all = 1'b1;
        #1;
        n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_req_ready: got %b, required 0", wr_ready); end
        tick();
        clr_all = 1'b0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (wr_ready !== 1'b0) saw_ready = 1;
            tick();
        end
        n_chk++; if (cnt != 8) begin n_fail++; $display("FAIL clr_busy_len: got %0d, required 8", cnt); end
        n_chk++; if (saw_ready) begin n_fail++; $display("FAIL clr_ready_busy: got 1, required 0"); end
        n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after: got %b, required 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] x;
            x = (i == 4) ? 2'b11 : 2'b00;
            rd_ch = 3'(i);
            sb.push_back('{3'(i), x, x});
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL clr_rd_ch%0d: got %b, required %b", e.ch, rd_data, e.e8); end
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL clr_rd6_ch%0d: got %b, required %b", e.ch, rd_data6, e.e6); end
        end
    endtask

    task automatic test_back_to_back();
        rd_exp_t lst [3];
        rd_exp_t e;
        lst[0] = '{3'd1, 2'b11, 2'b11};
        lst[1] = '{3'd2, 2'b00, 2'b00};
        lst[2] = '{3'd4, 2'b10, 2'b10};
        wr(3'd1, 1'b1, 2'b01);
        wr(3'd1, 1'b1, 2'b10);
        wr(3'd2, 1'b1, 2'b10);
        wr(3'd2, 1'b0, 2'b10);
        wr(3'd4, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            rd_ch = lst[i].ch;
            sb.push_back(lst[i]);
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL b2b_ch%0d: got %b, required %b", e.ch, rd_data, e.e8); end
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL b2b6_ch%0d: got %b, required %b", e.ch, rd_data6, e.e6); end
        end
    endtask

    task automatic test_out_of_range();
        rd_exp_t lst [2];
        rd_exp_t e;
        int w = 0;
        lst[0] = '{3'd7, 2'b11, 2'b00};
        lst[1] = '{3'd6, 2'b00, 2'b00};
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        while (busy === 1'b1 && w < 20) begin
            w++;
            tick();
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oor_clr_timeout: busy got %b, required 0", busy); end
        n_chk++; if (wr_ready6 !== 1'b1) begin n_fail++; $display("FAIL oor_ready6: got %b, required 1", wr_ready6); end
        wr(3'd7, 1'b1, 2'b11);
        tick();
        n_chk++; if (any_a6 !== 1'b0 || any_b6 !== 1'b0) begin n_fail++; $display("FAIL oor_any6: got %b%b, required 00", any_a6, any_b6); end
        n_chk++; if (any_a !== 1'b1 || any_b !== 1'b1) begin n_fail++; $display("FAIL oor_any8: got %b%b, required 11", any_a, any_b); end
        for (int i = 0; i < 2; i++) begin
            rd_ch = lst[i].ch;
            sb.push_back(lst[i]);
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL oor_ch%0d: got %b, required %b", e.ch, rd_data, e.e8); end
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL oor6_ch%0d: got %b, required %b", e.ch, rd_data6, e.e6); end
        end
    endtask

`ifdef STATUS_BANK_TIMEOUT_EN
    task automatic test_timeout();
        rd_exp_t e;
        logic [1:0] x;
        wr(3'd2, 1'b1, 2'b11);
        rd_ch = 3'd2;
        for (int j = 1; j <= 6; j++) begin
            x = (j <= 4) ? 2'b11 : 2'b00;
            sb.push_back('{3'd2, 2'b11, x});
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL expire_c%0d: got %b, required %b", j, rd_data6, e.e6); end
            n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL noexpire_c%0d: got %b, required %b", j, rd_data, e.e8); end
        end
        wr(3'd2, 1'b1, 2'b11);
        repeat (3) tick();
        wr(3'd2, 1'b1, 2'b11);
        for (int j = 1; j <= 6; j++) begin
            x = (j <= 4) ? 2'b11 : 2'b00;
            sb.push_back('{3'd2, 2'b11, x});
            tick();
            e = sb.pop_front();
            n_chk++; if (rd_data6 !== e.e6) begin n_fail++; $display("FAIL reload_c%0d: got %b, required %b", j, rd_data6, e.e6); end
        end
    endtask
`endif

    task automatic test_reset_mid_clear();
        rd_exp_t e;
        wr(3'd0, 1'b1, 2'b11);
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmc_busy_pre: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || busy6 !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %b%b, required 00", busy, busy6); end
        n_chk++; if (rd_data !== 2'b00) begin n_fail++; $display("FAIL rmc_rd: got %b, required 00", rd_data); end
        n_chk++; if (any_a !== 1'b0 || any_b !== 1'b0) begin n_fail++; $display("FAIL rmc_any: got %b%b, required 00", any_a, any_b); end
        #3 rst_n = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_idle: got %b, required 0", busy); end
        n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready: got %b, required 1", wr_ready); end
        rd_ch = 3'd7;
        sb.push_back('{3'd7, 2'b00, 2'b00});
        tick();
        e = sb.pop_front();
        n_chk++; if (rd_data !== e.e8) begin n_fail++; $display("FAIL rmc_rd_ch7: got %b, required %b", rd_data, e.e8); end
    endtask

    initial begin
        test_reset();
        test_set_read();
        test_set_clear();
        test_same_cycle();
        test_clear_all();
        test_back_to_back();
        test_out_of_range();
`ifdef STATUS_BANK_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
